// File: rtl/mel_filterbank_stream.sv
// Streaming Mel filterbank: buffers one frame of FFT bins, then produces N_BANDS weighted sums.
// Optional macro MEL_SATURATE_EN selects clamping instead of wrapping on output reduction.
module mel_filterbank_stream #(
  parameter int N_BINS    = 16,
  parameter int N_BANDS   = 13,
  parameter int DW        = 16,
  parameter int CW        = 16,
  parameter int COEF_FRAC = 8,
  parameter int ACC_W     = 40
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [DW-1:0]                        s_data,
  input  logic                                 s_last,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [DW-1:0]                        m_data,
  output logic                                 m_last,
  input  logic                                 coef_we,
  input  logic [$clog2(N_BINS*N_BANDS)-1:0]    coef_addr,
  input  logic [CW-1:0]                        coef_wdata,
  output logic                                 busy,
  output logic                                 frame_err
);

  localparam int DEPTH  = N_BINS * N_BANDS;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BIN_W  = $clog2(N_BINS);
  localparam int BAND_W = (N_BANDS > 1) ? $clog2(N_BANDS) : 1;
  localparam int PW     = DW + CW;

  localparam logic [BIN_W-1:0]  BIN_LAST  = BIN_W'(N_BINS - 1);
  localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(N_BANDS - 1);

  typedef enum logic [1:0] {S_LOAD, S_MAC, S_OUT} state_t;

  state_t r_state, w_state_next;

  logic [BIN_W-1:0]         r_bin;
  logic [BAND_W-1:0]        r_band;
  logic signed [ACC_W-1:0]  r_acc;
  logic [DW-1:0]            r_buf  [N_BINS];
  logic [CW-1:0]            r_coef [DEPTH];
  logic [DW-1:0]            r_m_data;
  logic                     r_m_last;
  logic                     r_frame_err;

  logic                     w_in_xfer;
  logic                     w_frame_end;
  logic                     w_bin_last;
  logic                     w_band_last;
  logic [ADDR_W-1:0]        w_caddr;
  logic [DW-1:0]            w_x;
  logic [CW-1:0]            w_c;
  logic signed [PW-1:0]     w_xe;
  logic signed [PW-1:0]     w_ce;
  logic signed [PW-1:0]     w_prod;
  logic signed [PW-1:0]     w_prod_sh;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic [DW-1:0]            w_red;

  assign w_in_xfer   = (r_state == S_LOAD) && s_valid;
  assign w_bin_last  = (r_bin == BIN_LAST);
  assign w_band_last = (r_band == BAND_LAST);
  assign w_frame_end = w_in_xfer && (s_last || w_bin_last);

  // Multiply-accumulate datapath for the current (bin, band) pair
  assign w_caddr    = ADDR_W'(r_bin) * ADDR_W'(N_BANDS) + ADDR_W'(r_band);
  assign w_x        = r_buf[r_bin];
  assign w_c        = r_coef[w_caddr];
  assign w_xe       = {{CW{w_x[DW-1]}}, w_x};
  assign w_ce       = {{DW{w_c[CW-1]}}, w_c};
  assign w_prod     = w_xe * w_ce;
  assign w_prod_sh  = w_prod >>> COEF_FRAC;
  assign w_prod_ext = {{(ACC_W-PW){w_prod_sh[PW-1]}}, w_prod_sh};
  assign w_acc_next = r_acc + w_prod_ext;

`ifdef MEL_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
  always_comb begin
    w_red = w_acc_next[DW-1:0];
    if (w_acc_next > SAT_MAX)
      w_red = SAT_MAX[DW-1:0];
    else if (w_acc_next < SAT_MIN)
      w_red = SAT_MIN[DW-1:0];
  end
`else
  assign w_red = w_acc_next[DW-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_LOAD;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_LOAD: if (w_frame_end) w_state_next = S_MAC;
      S_MAC:  if (w_bin_last)  w_state_next = S_OUT;
      S_OUT:  if (m_ready)     w_state_next = w_band_last ? S_LOAD : S_MAC;
      default:                 w_state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin       <= '0;
      r_band      <= '0;
      r_acc       <= '0;
      r_m_data    <= '0;
      r_m_last    <= 1'b0;
      r_frame_err <= 1'b0;
      for (int unsigned i = 0; i < N_BINS; i++) r_buf[i] <= '0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (w_in_xfer) begin
            r_buf[r_bin] <= s_data;
            if (w_frame_end) begin
              r_bin       <= '0;
              r_band      <= '0;
              r_acc       <= '0;
              r_frame_err <= w_bin_last && !s_last;
            end else begin
              r_bin <= r_bin + 1'b1;
            end
          end
        end
        S_MAC: begin
          r_acc <= w_acc_next;
          if (w_bin_last) begin
            r_bin    <= '0;
            r_m_data <= w_red;
            r_m_last <= w_band_last;
          end else begin
            r_bin <= r_bin + 1'b1;
          end
        end
        S_OUT: begin
          if (m_ready) begin
            r_acc <= '0;
            r_bin <= '0;
            if (w_band_last) begin
              r_band <= '0;
              for (int unsigned i = 0; i < N_BINS; i++) r_buf[i] <= '0;
            end else begin
              r_band <= r_band + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Coefficient RAM is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (coef_we && ({1'b0, coef_addr} < (ADDR_W+1)'(DEPTH)))
      r_coef[coef_addr] <= coef_wdata;
  end

  assign s_ready   = (r_state == S_LOAD);
  assign m_valid   = (r_state == S_OUT);
  assign busy      = (r_state != S_LOAD);
  assign m_data    = r_m_data;
  assign m_last    = r_m_last;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_mel_filterbank_stream.sv
// Randomized self-checking bench for mel_filterbank_stream against an arithmetic reference model.
module tb_mel_filterbank_stream;

  localparam int NBIN  = 16;
  localparam int NBAND = 13;
  localparam int DW    = 16;
  localparam int AW    = $clog2(NBIN*NBAND);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          coef_we = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [15:0]   coef_wdata = '0;
  logic          busy;
  logic          frame_err;

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;

  int x    [NBIN];
  int coef [NBIN*NBAND];

  mel_filterbank_stream #(
    .N_BINS(NBIN), .N_BANDS(NBAND), .DW(DW), .CW(16), .COEF_FRAC(8), .ACC_W(40)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && frame_err) err_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Feature b = reduce( sum_j (x[j]*coef(j,b)) >>> 8 )
  function automatic logic [15:0] model_band(input int b);
    longint acc = 0;
    logic [15:0] r;
    for (int j = 0; j < NBIN; j++)
      acc += (longint'(x[j]) * longint'(coef[j*NBAND+b])) >>> 8;
`ifdef MEL_SATURATE_EN
    if (acc > 32767)       r = 16'h7FFF;
    else if (acc < -32768) r = 16'h8000;
    else                   r = 16'(acc);
`else
    r = 16'(acc);
`endif
    return r;
  endfunction

  task automatic load_coefs();
    for (int i = 0; i < NBIN*NBAND; i++) begin
      @(negedge clk);
      coef_we    = 1'b1;
      coef_addr  = AW'(i);
      coef_wdata = 16'(coef[i]);
    end
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic set_identity();
    for (int j = 0; j < NBIN; j++)
      for (int b = 0; b < NBAND; b++)
        coef[j*NBAND+b] = (j == b) ? 256 : 0;
  endtask

  task automatic set_random_coefs();
    logic [15:0] r;
    for (int i = 0; i < NBIN*NBAND; i++) begin
      r = 16'($urandom);
      coef[i] = int'($signed(r));
    end
  endtask

  task automatic random_bins(input int n);
    logic [15:0] r;
    for (int i = 0; i < NBIN; i++) begin
      r = 16'($urandom);
      x[i] = (i < n) ? int'($signed(r)) : 0;
    end
  endtask

  task automatic send_frame(input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      @(negedge clk);
      while (!s_ready && w < 400) begin
        @(negedge clk);
        w++;
      end
      if (!s_ready) begin
        check("s_ready_timeout", s_ready, 1);
        s_valid = 1'b0;
        return;
      end
      s_valid = 1'b1;
      s_data  = 16'(x[i]);
      s_last  = with_last && (i == n-1);
      @(posedge clk);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic collect_frame(input int bp_pct);
    for (int b = 0; b < NBAND; b++) begin
      int n = 0;
      while (!m_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!m_valid) begin
        check("m_valid_timeout", m_valid, 1);
        return;
      end
      for (int s = 0; s < 4 && $urandom_range(99) < bp_pct; s++) begin
        m_ready = 1'b0;
        @(negedge clk);
      end
      check($sformatf("feature%0d", b), m_data, model_band(b));
      check($sformatf("last%0d", b), m_last, (b == NBAND-1));
      m_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      m_ready = 1'b0;
    end
  endtask

  initial begin
    int n;
    int e0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_s_ready", s_ready, 1);

    // Identity filterbank with first-feature latency
    set_identity();
    load_coefs();
    for (int i = 0; i < NBIN; i++) x[i] = i + 1;
    send_frame(NBIN, 1'b1);
    n = 0;
    while (!m_valid && n < 100) begin
      check("mac_s_ready", s_ready, 0);
      @(negedge clk);
      n++;
    end
    // n counts edges after the transfer edge; +1 counts the transfer cycle itself
    check("latency", n + 1, NBIN + 1);
    collect_frame(0);

    // Full-scale coefficients and bins
    for (int i = 0; i < NBIN*NBAND; i++) coef[i] = 32767;
    for (int i = 0; i < NBIN; i++) x[i] = 32767;
    load_coefs();
    send_frame(NBIN, 1'b1);
    collect_frame(30);

    // Output backpressure: held feature must not change or advance
    set_random_coefs();
    load_coefs();
    random_bins(NBIN);
    send_frame(NBIN, 1'b1);
    n = 0;
    while (!m_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int s = 0; s < 5; s++) begin
      check("bp_m_valid", m_valid, 1);
      check("bp_m_data", m_data, model_band(0));
      check("bp_m_last", m_last, 0);
      check("bp_s_ready", s_ready, 0);
      check("bp_busy", busy, 1);
      @(negedge clk);
    end
    collect_frame(0);

    // Short frame ended by s_last; tail bins must read as zero
    set_identity();
    load_coefs();
    for (int i = 0; i < NBIN; i++) x[i] = (i < 4) ? i + 5 : 0;
    e0 = err_cnt;
    send_frame(4, 1'b1);
    collect_frame(20);
    check("short_no_err", err_cnt - e0, 0);

    // Overrun: full frame without s_last
    random_bins(NBIN);
    e0 = err_cnt;
    send_frame(NBIN, 1'b0);
    collect_frame(0);
    check("overrun_err_once", err_cnt - e0, 1);

    // Reset in the middle of MAC discards the frame
    random_bins(NBIN);
    send_frame(NBIN, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_s_ready", s_ready, 1);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    random_bins(NBIN);
    send_frame(NBIN, 1'b1);
    collect_frame(0);

    // Random frames, lengths and backpressure
    for (int f = 0; f < 6; f++) begin
      int len;
      bit lst;
      if (f % 2 == 0) begin
        set_random_coefs();
        load_coefs();
      end
      len = $urandom_range(NBIN, 1);
      lst = (len < NBIN) ? 1'b1 : 1'($urandom_range(1));
      random_bins(len);
      e0 = err_cnt;
      send_frame(len, lst);
      collect_frame(40);
      check("rand_err", err_cnt - e0, (len == NBIN && !lst) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
